exec_trace_buffer: RTL
======================

EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32, is the width of the sampled PC and ALU result.
REQ-002 Parameter DEPTH, default 16, is the number of trace entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter HALT_CYCLES, default 4, is the number of consecutive repeated-PC samples that declares a halt; it SHALL be at least 1.
REQ-004 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; reset=0 SHALL clear all state immediately, independent of clock.
REQ-006 start  in  1  single-cycle capture request.
REQ-007 pc_in  in  DATA_W  processor PC sampled each cycle.
REQ-008 ula_in  in  DATA_W  processor ALU result sampled each cycle.
REQ-009 rd_ready  in  1  consumer accepts the head entry.
REQ-010 rd_valid  out  1  the head entry is present.
REQ-011 rd_pc, rd_ula  out  DATA_W each  PC and ALU fields of the head entry.
REQ-012 rd_cycle  out  32  cycle stamp of the head entry.
REQ-013 count  out  log2(DEPTH)+1  number of stored entries.
REQ-014 cycle_cnt  out  32  number of capture cycles since the last start.
REQ-015 overflow  out  1  sticky flag: an unread entry was overwritten.
REQ-016 halted  out  1  a halt has been detected.
REQ-017 state  out  2  FSM state encoding: IDLE=0, RUN=1, HALT=2.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and HALT.
REQ-019 IDLE: start=1 SHALL move the FSM to RUN on the next edge.
REQ-020 Taking start in IDLE or in HALT SHALL, on that same edge, clear the buffer, count, cycle_cnt, overflow, halted and the halt tracker.
REQ-021 RUN: start SHALL be ignored.
REQ-022 RUN: every edge SHALL write the entry {pc_in, ula_in, cycle_cnt} at the tail and then increment cycle_cnt.
REQ-023 cycle_cnt SHALL wrap from 2^32-1 to 0.
REQ-024 Write when count<DEPTH: the entry SHALL be appended and count SHALL increment.
REQ-025 Write when count=DEPTH with no pop: the oldest entry SHALL be overwritten, the head SHALL advance, count SHALL stay DEPTH, and overflow SHALL be set.
REQ-026 Write and pop in the same cycle: count SHALL be unchanged and overflow SHALL NOT be set, including when count=DEPTH.
REQ-027 Pop: when rd_valid=1 and rd_ready=1, the head SHALL advance and count SHALL decrement; pops SHALL be legal in every state.
REQ-028 rd_valid SHALL equal (count!=0); rd_pc, rd_ula and rd_cycle SHALL show the head entry combinationally, with first-word fall-through.
REQ-029 rd_ready with count=0 SHALL have no effect.
REQ-030 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-031 Halt tracker: while in RUN, each sample equal to the previous sample's pc_in SHALL increment a repeat counter; an unequal sample SHALL zero it; the first sample after start has no predecessor and SHALL NOT count.
REQ-032 When the repeat counter reaches HALT_CYCLES, the completing sample SHALL still be written, and on that edge the FSM SHALL enter HALT and halted SHALL be set.
REQ-033 HALT: no writes SHALL occur, cycle_cnt SHALL freeze, and reads SHALL continue.
REQ-034 halted and overflow SHALL be cleared only by reset or by a start taken per REQ-020.

Reset
REQ-035 While reset=0: state=IDLE; count=0; rd_valid=0; cycle_cnt=0; overflow=0; halted=0; pointers=0; repeat counter=0.
REQ-036 While reset=0, rd_pc, rd_ula and rd_cycle SHALL read 0.
REQ-037 Storage contents need not be cleared by reset; they SHALL never be visible while count=0.
REQ-038 Reset asserted mid-RUN SHALL abort capture at once; after release the block SHALL stay in IDLE until start.

Verification (DEPTH=4, HALT_CYCLES=3)
REQ-039 Reset release, start=1 for one cycle, pc_in=0,4,8 on successive RUN cycles, rd_ready=0 -> count=3, cycle_cnt=3, head={0, ula, 0}.
REQ-040 Six RUN writes with rd_ready=0, pc_in=0,4,...,20 -> count=4, overflow=1, head pc=8, head rd_cycle=2.
REQ-041 Full buffer, rd_ready=1 during one write -> count stays 4, overflow stays 0, head advances by one.
REQ-042 pc_in=0,4,8,8,8,8 -> halted=1 and state=HALT after the 6th sample; cycle_cnt=6 frozen; pc_in=12 afterwards is not captured.
REQ-043 In HALT, drain with rd_ready=1 -> 4 pops, then rd_valid=0; start then clears halted, overflow and cycle_cnt and returns the FSM to RUN.
REQ-044 reset=0 pulse mid-RUN, not aligned to clock -> all outputs 0 immediately, state=IDLE; no capture until the next start.

Source files
------------

// File: rtl/exec_trace_if.sv
// exec_trace_if: capture inputs, read handshake and status of the execution trace buffer
interface exec_trace_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              start_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] ula_i;
  logic              rd_ready_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_pc_o;
  logic [DATA_W-1:0] rd_ula_o;
  logic [31:0]       rd_cycle_o;
  logic [CW-1:0]     count_o;
  logic [31:0]       cycle_cnt_o;
  logic              overflow_o;
  logic              halted_o;
  logic [1:0]        state_o;
  modport master (
    output start_i, pc_i, ula_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_ula_o, rd_cycle_o, count_o, cycle_cnt_o, overflow_o, halted_o, state_o
  );
  modport slave (
    input  start_i, pc_i, ula_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_ula_o, rd_cycle_o, count_o, cycle_cnt_o, overflow_o, halted_o, state_o
  );
endinterface

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: circular PC/ALU trace capture with repeated-PC halt detection
module exec_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  exec_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(HALT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
  state_e            state_q;
  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       cyc_q;
  logic              ovf_q, halted_q, has_prev_q;
  logic [RW-1:0]     rep_q, rep_d;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] pc_mem  [DEPTH];
  logic [DATA_W-1:0] ula_mem [DEPTH];
  logic [31:0]       cyc_mem [DEPTH];
  logic              wr, pop, clr, full;
  always_comb begin
    wr      = state_q == RUN;
    pop     = count_q != '0 && bus.rd_ready_i;
    clr     = bus.start_i && state_q != RUN;
    full    = count_q == CW'(DEPTH);
    count_d = wr && !pop ? (full ? count_q : count_q + 1'b1) : (!wr && pop ? count_q - 1'b1 : count_q);
    rep_d   = has_prev_q && bus.pc_i == prev_q ? rep_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      ovf_q      <= 1'b0;
      halted_q   <= 1'b0;
      has_prev_q <= 1'b0;
      rep_q      <= '0;
      prev_q     <= '0;
    end else if (clr) begin
      state_q    <= RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      ovf_q      <= 1'b0;
      halted_q   <= 1'b0;
      has_prev_q <= 1'b0;
      rep_q      <= '0;
    end else begin
      count_q <= count_d;
      // a write into a full buffer drops the oldest entry unless a pop already consumes it
      if (pop || (wr && full)) head_q <= head_q + 1'b1;
      if (wr) begin
        tail_q     <= tail_q + 1'b1;
        cyc_q      <= cyc_q + 1'b1;
        ovf_q      <= ovf_q | (full && !pop);
        prev_q     <= bus.pc_i;
        has_prev_q <= 1'b1;
        rep_q      <= rep_d;
        if (rep_d == RW'(HALT_CYCLES)) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[tail_q]  <= bus.pc_i;
      ula_mem[tail_q] <= bus.ula_i;
      cyc_mem[tail_q] <= cyc_q;
    end
  end
  assign bus.rd_valid_o  = count_q != '0;
  assign bus.rd_pc_o     = bus.rd_valid_o ? pc_mem[head_q] : '0;
  assign bus.rd_ula_o    = bus.rd_valid_o ? ula_mem[head_q] : '0;
  assign bus.rd_cycle_o  = bus.rd_valid_o ? cyc_mem[head_q] : '0;
  assign bus.count_o     = count_q;
  assign bus.cycle_cnt_o = cyc_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.halted_o    = halted_q;
  assign bus.state_o     = state_q;
endmodule
